wb_stage_lsu: RTL and testbench
===============================

Name: wb_stage_lsu

Overview:
Writeback stage for variable-latency data memory. Accepts one MEM/WB instruction per cycle over a valid/ready handshake and holds a load until `dmem_rvalid` returns. It aligns and sign/zero-extends load data, selects the writeback source, and drives a registered register-file write port. It sits between the MEM/WB pipeline register and the register file, and back-pressures the pipeline through `in_ready`.

Parameters:
XLEN, 32, datapath width; 32 or 64 only
LOAD_TIMEOUT, 16, max cycles spent in WAIT_LOAD before abort; must be >= 2
TMO_W, $clog2(LOAD_TIMEOUT+1), timeout counter width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  MEM/WB instruction valid
in_ready  out  1  stage can accept an instruction
in_mem_to_reg  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 alt (CSR/LUI)
in_alu_result  in  XLEN  ALU result; also the load effective address
in_pc_plus_4  in  XLEN  return address
in_alt_data  in  XLEN  CSR read / upper-immediate data
in_funct3  in  3  load size/sign encoding (RISC-V funct3)
in_rd  in  5  destination register
in_reg_write  in  1  instruction writes rd
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  raw aligned-word read data
rf_we  out  1  register-file write enable
rf_rd  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data
misalign_err  out  1  one-cycle pulse: misaligned load dropped
load_timeout  out  1  one-cycle pulse: load aborted

Behaviour:
- Reset (`rst_n`=0 at a clk edge): state IDLE; `rf_we`, `rf_rd`, `rf_wdata`, `misalign_err`, `load_timeout` and the timeout counter all 0. Any held load is discarded.
- States:
  - IDLE: `in_ready`=1.
  - WAIT_LOAD: `in_ready`=0.
- Accept occurs when `in_valid` && `in_ready`.
- Non-load accept (`mem_to_reg` != 01):
  - Next cycle: `rf_we` = `in_reg_write` && (`in_rd` != 0), `rf_rd` = `in_rd`, `rf_wdata` = selected source.
  - Latency is 1. State stays IDLE.
- Load accept with `dmem_rvalid`=1 in the same cycle: complete as a non-load, using the extracted data. Latency 1, state stays IDLE.
- Load accept with `dmem_rvalid`=0: latch rd, reg_write, funct3 and address offset; go to WAIT_LOAD; clear the counter.
- WAIT_LOAD:
  - `dmem_rvalid`=1: write the extracted data next cycle and return to IDLE. A new instruction is accepted no earlier than the following cycle.
  - `dmem_rvalid`=0: increment the counter. When the counter reaches LOAD_TIMEOUT-1 with no rvalid, pulse `load_timeout` next cycle, keep `rf_we`=0, return to IDLE.
- `dmem_rvalid` in IDLE without a load accept is ignored.
- `rf_we` is a single-cycle pulse per completed instruction. `rf_rd` and `rf_wdata` hold their last value when `rf_we`=0.
- Load extraction:
  - Offset = `in_alu_result[$clog2(XLEN/8)-1:0]`.
  - LB/LBU (000/100): byte at offset·8.
  - LH/LHU (001/101): halfword at offset·8.
  - LW (010): word at offset·8.
  - LWU (110) and LD (011): XLEN=64 only.
  - Signed forms sign-extend to XLEN; unsigned forms zero-extend.
- Misalignment (halfword with offset[0]=1; word with offset[1:0] != 0; doubleword with offset != 0):
  - No write; `misalign_err` pulses in the completion cycle.
  - Detected at accept, so the stage never enters WAIT_LOAD for a misaligned load. The memory response is not awaited.
- Illegal funct3 (111, or 011/110 when XLEN=32): treated as misaligned.
- Unknown `mem_to_reg` cannot occur (all 4 codes are defined).

Decomposition:
- riscv_pkg additions: `wb_sel_e` enum (WB_ALU, WB_MEM, WB_PC4, WB_ALT) and `load_f3_e` enum of funct3 load codes.
- Sub-module `load_align` (pure combinational): inputs funct3, offset, raw data; outputs extended data and a misaligned flag. It is reused by any future LSU.
- The FSM, timeout counter and output register live in `wb_stage_lsu`.

Test Plan:
- ALU op, rd=5, alu=0x1234, `mem_to_reg`=00 -> next cycle `rf_we`=1, `rf_rd`=5, `rf_wdata`=0x1234; `in_ready` stays 1.
- LB, addr=0x1003, `dmem_rdata`=0x80FF_FFFF, rvalid same cycle -> `rf_wdata`=0xFFFF_FF80, latency 1.
- LHU, addr offset 2, rvalid 3 cycles late, `rdata`=0xBEEF_0000 -> `in_ready`=0 for 4 cycles; `rf_wdata`=0x0000_BEEF one cycle after rvalid.
- LW at addr 0x2002 -> `misalign_err` pulse, `rf_we`=0, stage stays IDLE.
- Load with no rvalid, LOAD_TIMEOUT=16 -> `load_timeout` pulses 16 cycles after accept, `rf_we`=0, then `in_ready`=1.
- Load waiting, `rst_n`=0 for 1 cycle, then late rvalid -> no write, state IDLE; JAL with rd=0 -> `rf_we`=0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RISC-V pipeline types: writeback source select,
//               funct3 load encodings and writeback-stage FSM states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Writeback source select, matching the MEM/WB mem_to_reg field.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_ALT = 2'b11
  } wb_sel_e;

  // RISC-V load funct3 codes. 3'b111 is not a load and has no entry.
  typedef enum logic [2:0] {
    LF3_LB  = 3'b000,
    LF3_LH  = 3'b001,
    LF3_LW  = 3'b010,
    LF3_LD  = 3'b011,
    LF3_LBU = 3'b100,
    LF3_LHU = 3'b101,
    LF3_LWU = 3'b110
  } load_f3_e;

  // Writeback-stage FSM states.
  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load data extraction. Shifts the raw aligned
//               word down to the addressed byte lane, sign/zero-extends to
//               XLEN and flags misaligned or illegal load encodings.
// Ports       : funct3     - load size/sign encoding
//               offset     - byte offset within the XLEN-wide word
//               rdata      - raw aligned-word read data
//               data       - extracted, extended load data
//               misaligned - access misaligned or funct3 illegal for XLEN
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN-1:0]             data,
  output logic                        misaligned
);

  localparam bit IS_RV64 = (XLEN == 64);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // Bring the addressed byte lane down to bit 0; size handling below only
    // needs the low bits of the shifted word.
    shifted    = rdata >> {offset, 3'b000};
    data       = '0;
    misaligned = 1'b0;
    case (funct3)
      LF3_LB:  data = XLEN'($signed(shifted[7:0]));
      LF3_LBU: data = XLEN'(shifted[7:0]);
      LF3_LH: begin
        data       = XLEN'($signed(shifted[15:0]));
        misaligned = offset[0];
      end
      LF3_LHU: begin
        data       = XLEN'(shifted[15:0]);
        misaligned = offset[0];
      end
      LF3_LW: begin
        data       = XLEN'($signed(shifted[31:0]));
        misaligned = (offset[1:0] != 2'b00);
      end
      LF3_LWU: begin
        data       = XLEN'(shifted[31:0]);
        misaligned = !IS_RV64 || (offset[1:0] != 2'b00);
      end
      LF3_LD: begin
        data       = shifted;
        misaligned = !IS_RV64 || (offset != '0);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_lsu
// Description : Writeback stage for variable-latency data memory. Accepts one
//               MEM/WB instruction per cycle, holds a load until dmem_rvalid,
//               aligns/extends load data and drives a registered RF write.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               in_valid/in_ready   - MEM/WB handshake
//               in_mem_to_reg       - writeback source select
//               in_alu_result       - ALU result / load effective address
//               in_pc_plus_4        - return address
//               in_alt_data         - CSR / upper-immediate data
//               in_funct3, in_rd, in_reg_write - instruction fields
//               dmem_rvalid/rdata   - load response
//               rf_we/rf_rd/rf_wdata - registered register-file write port
//               misalign_err        - pulse: misaligned load dropped
//               load_timeout        - pulse: load aborted
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_mem_to_reg,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus_4,
  input  logic [XLEN-1:0] in_alt_data,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            misalign_err,
  output logic            load_timeout
);

  localparam int TMO_W = $clog2(LOAD_TIMEOUT + 1);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

  wb_state_e         state, state_nx;
  logic [TMO_W-1:0]  cnt, cnt_nx;
  logic [4:0]        held_rd, held_rd_nx;
  logic              held_rw, held_rw_nx;
  logic [2:0]        held_f3, held_f3_nx;
  logic [OFF_W-1:0]  held_off, held_off_nx;

  logic              we_nx, mis_nx, tmo_nx;
  logic [4:0]        rd_nx;
  logic [XLEN-1:0]   wdata_nx;

  logic [2:0]        align_f3;
  logic [OFF_W-1:0]  align_off;
  logic [XLEN-1:0]   align_data;
  logic              align_mis;
  logic [XLEN-1:0]   src_data;
  wb_sel_e           sel;

  assign sel = wb_sel_e'(in_mem_to_reg);

  // One extractor serves both paths: the live instruction while IDLE and the
  // latched load fields while waiting for the response.
  assign align_f3  = (state == WB_WAIT_LOAD) ? held_f3  : in_funct3;
  assign align_off = (state == WB_WAIT_LOAD) ? held_off : in_alu_result[OFF_W-1:0];

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .funct3     (align_f3),
    .offset     (align_off),
    .rdata      (dmem_rdata),
    .data       (align_data),
    .misaligned (align_mis)
  );

  always_comb begin
    src_data = in_alu_result;
    case (sel)
      WB_ALU:  src_data = in_alu_result;
      WB_MEM:  src_data = align_data;
      WB_PC4:  src_data = in_pc_plus_4;
      WB_ALT:  src_data = in_alt_data;
      default: src_data = in_alu_result;
    endcase
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    held_rd_nx  = held_rd;
    held_rw_nx  = held_rw;
    held_f3_nx  = held_f3;
    held_off_nx = held_off;
    we_nx       = 1'b0;
    rd_nx       = rf_rd;
    wdata_nx    = rf_wdata;
    mis_nx      = 1'b0;
    tmo_nx      = 1'b0;
    in_ready    = 1'b0;

    case (state)
      WB_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ((sel == WB_MEM) && align_mis) begin
            // Dropped at accept; the memory response is never awaited.
            mis_nx = 1'b1;
          end else if ((sel == WB_MEM) && !dmem_rvalid) begin
            held_rd_nx  = in_rd;
            held_rw_nx  = in_reg_write;
            held_f3_nx  = in_funct3;
            held_off_nx = in_alu_result[OFF_W-1:0];
            cnt_nx      = '0;
            state_nx    = WB_WAIT_LOAD;
          end else begin
            we_nx = in_reg_write && (in_rd != 5'd0);
            if (we_nx) begin
              rd_nx    = in_rd;
              wdata_nx = src_data;
            end
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          we_nx = held_rw && (held_rd != 5'd0);
          if (we_nx) begin
            rd_nx    = held_rd;
            wdata_nx = align_data;
          end
          state_nx = WB_IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo_nx   = 1'b1;
          state_nx = WB_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= WB_IDLE;
      cnt          <= '0;
      held_rd      <= '0;
      held_rw      <= 1'b0;
      held_f3      <= '0;
      held_off     <= '0;
      rf_we        <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
      misalign_err <= 1'b0;
      load_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      held_rd      <= held_rd_nx;
      held_rw      <= held_rw_nx;
      held_f3      <= held_f3_nx;
      held_off     <= held_off_nx;
      rf_we        <= we_nx;
      rf_rd        <= rd_nx;
      rf_wdata     <= wdata_nx;
      misalign_err <= mis_nx;
      load_timeout <= tmo_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_stage_lsu
// Description : Self-checking bench for wb_stage_lsu (XLEN=32,
//               LOAD_TIMEOUT=16). Completion events are matched against a
//               scoreboard queue; scenario tasks check timing inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage_lsu;

  localparam int XLEN = 32;
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_MIS = 2'd1;
  localparam logic [1:0] K_TMO = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_mem_to_reg;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_pc_plus_4;
  logic [XLEN-1:0] in_alt_data;
  logic [2:0]      in_funct3;
  logic [4:0]      in_rd;
  logic            in_reg_write;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic            misalign_err;
  logic            load_timeout;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_exp;
  logic [1:0] mon_kind;

  wb_stage_lsu #(
    .XLEN         (XLEN),
    .LOAD_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_to_reg (in_mem_to_reg),
    .in_alu_result (in_alu_result),
    .in_pc_plus_4  (in_pc_plus_4),
    .in_alt_data   (in_alt_data),
    .in_funct3     (in_funct3),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .misalign_err  (misalign_err),
    .load_timeout  (load_timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every completion event must match the queue head.
  always @(negedge clk) begin
    if (rst_n && (rf_we || misalign_err || load_timeout)) begin
      checks++;
      mon_kind = rf_we ? K_WR : (misalign_err ? K_MIS : K_TMO);
      if ((32'(rf_we) + 32'(misalign_err) + 32'(load_timeout)) > 1) begin
        errors++;
        $display("FAIL multi_event we=%b mis=%b tmo=%b", rf_we, misalign_err, load_timeout);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%0d rd=%0d data=%h", mon_kind, rf_rd, rf_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_kind !== mon_exp.kind ||
            (mon_exp.kind == K_WR && (rf_rd !== mon_exp.rd || rf_wdata !== mon_exp.data))) begin
          errors++;
          $display("FAIL scoreboard got kind=%0d rd=%0d data=%h expected kind=%0d rd=%0d data=%h",
                   mon_kind, rf_rd, rf_wdata, mon_exp.kind, mon_exp.rd, mon_exp.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one instruction for exactly one clock edge (called #1 after an edge).
  task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rw, input logic rv,
                       input logic [31:0] rdata);
    in_valid      = 1'b1;
    in_mem_to_reg = sel;
    in_alu_result = alu;
    in_funct3     = f3;
    in_rd         = rd;
    in_reg_write  = rw;
    dmem_rvalid   = rv;
    dmem_rdata    = rdata;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0 ||
        misalign_err !== 1'b0 || load_timeout !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got we=%b rd=%0d wdata=%h mis=%b tmo=%b ready=%b expected 0 0 0 0 0 1",
               rf_we, rf_rd, rf_wdata, misalign_err, load_timeout, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    sb.push_back('{K_WR, 5'd5, 32'h0000_1234});
    drive(2'b00, 32'h0000_1234, 3'b000, 5'd5, 1'b1, 1'b0, 32'h0);
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h1234 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_latency got we=%b rd=%0d wdata=%h ready=%b expected 1 5 00001234 1",
               rf_we, rf_rd, rf_wdata, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'h1234) begin
      errors++;
      $display("FAIL we_pulse_hold got we=%b wdata=%h expected 0 00001234", rf_we, rf_wdata);
    end
    in_pc_plus_4 = 32'h0000_8004;
    sb.push_back('{K_WR, 5'd1, 32'h0000_8004});
    drive(2'b10, 32'hDEAD_BEEF, 3'b000, 5'd1, 1'b1, 1'b0, 32'h0);
    in_alt_data = 32'hABCD_0000;
    sb.push_back('{K_WR, 5'd31, 32'hABCD_0000});
    drive(2'b11, 32'h1111_1111, 3'b000, 5'd31, 1'b1, 1'b0, 32'h0);
    // reg_write=0: no write, outputs hold the previous write.
    drive(2'b00, 32'h5555_5555, 3'b000, 5'd3, 1'b0, 1'b0, 32'h0);
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd31 || rf_wdata !== 32'hABCD_0000) begin
      errors++;
      $display("FAIL no_reg_write got we=%b rd=%0d wdata=%h expected 0 31 abcd0000",
               rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_load_same_cycle();
    sb.push_back('{K_WR, 5'd10, 32'hFFFF_FF80});
    drive(2'b01, 32'h0000_1003, 3'b000, 5'd10, 1'b1, 1'b1, 32'h80FF_FFFF);
    checks++;
    if (rf_we !== 1'b1 || rf_wdata !== 32'hFFFF_FF80 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lb_same_cycle got we=%b wdata=%h ready=%b expected 1 ffffff80 1",
               rf_we, rf_wdata, in_ready);
    end
    sb.push_back('{K_WR, 5'd11, 32'h0000_0056});
    drive(2'b01, 32'h0000_2001, 3'b100, 5'd11, 1'b1, 1'b1, 32'h1234_5678);
    sb.push_back('{K_WR, 5'd12, 32'hFFFF_8001});
    drive(2'b01, 32'h0000_2002, 3'b001, 5'd12, 1'b1, 1'b1, 32'h8001_1234);
    sb.push_back('{K_WR, 5'd13, 32'hCAFE_F00D});
    drive(2'b01, 32'h0000_3000, 3'b010, 5'd13, 1'b1, 1'b1, 32'hCAFE_F00D);
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd13 || rf_wdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL lw_same_cycle got we=%b rd=%0d wdata=%h expected 1 13 cafef00d",
               rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_load_wait();
    int low_cycles;
    low_cycles = 0;
    sb.push_back('{K_WR, 5'd14, 32'h0000_BEEF});
    sb.push_back('{K_WR, 5'd7, 32'h0000_0777});
    drive(2'b01, 32'h0000_4002, 3'b101, 5'd14, 1'b1, 1'b0, 32'h0);
    // Upstream holds a stalled ALU instruction; it must wait for in_ready.
    in_valid      = 1'b1;
    in_mem_to_reg = 2'b00;
    in_alu_result = 32'h0000_0777;
    in_funct3     = 3'b000;
    in_rd         = 5'd7;
    in_reg_write  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (in_ready === 1'b0) low_cycles++;
      @(posedge clk);
      #1;
    end
    if (in_ready === 1'b0) low_cycles++;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_0000;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    checks++;
    if (low_cycles != 4) begin
      errors++;
      $display("FAIL lhu_wait_ready_low got %0d cycles expected 4", low_cycles);
    end
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd14 || rf_wdata !== 32'h0000_BEEF || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lhu_wait_complete got we=%b rd=%0d wdata=%h ready=%b expected 1 14 0000beef 1",
               rf_we, rf_rd, rf_wdata, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h0000_0777) begin
      errors++;
      $display("FAIL stalled_accept got we=%b rd=%0d wdata=%h expected 1 7 00000777",
               rf_we, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_misalign();
    sb.push_back('{K_MIS, 5'd0, 32'h0});
    drive(2'b01, 32'h0000_2002, 3'b010, 5'd15, 1'b1, 1'b0, 32'h0);
    checks++;
    if (misalign_err !== 1'b1 || rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lw_misalign got mis=%b we=%b ready=%b expected 1 0 1",
               misalign_err, rf_we, in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse got %b expected 0", misalign_err);
    end
    sb.push_back('{K_MIS, 5'd0, 32'h0});
    drive(2'b01, 32'h0000_2001, 3'b001, 5'd15, 1'b1, 1'b1, 32'h1234_5678);
    sb.push_back('{K_MIS, 5'd0, 32'h0});
    drive(2'b01, 32'h0000_2000, 3'b111, 5'd15, 1'b1, 1'b0, 32'h0);
    sb.push_back('{K_MIS, 5'd0, 32'h0});
    drive(2'b01, 32'h0000_2000, 3'b011, 5'd15, 1'b1, 1'b0, 32'h0);
    checks++;
    if (misalign_err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_illegal_rv32 got mis=%b ready=%b expected 1 1", misalign_err, in_ready);
    end
  endtask

  task automatic test_timeout();
    int waited;
    waited = 0;
    sb.push_back('{K_TMO, 5'd0, 32'h0});
    drive(2'b01, 32'h0000_5000, 3'b010, 5'd9, 1'b1, 1'b0, 32'h0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_enter_wait got ready=%b expected 0", in_ready);
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (load_timeout === 1'b1) begin
        waited = k;
        break;
      end
    end
    checks++;
    if (waited != 16) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles expected 16", waited);
    end
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_exit got we=%b ready=%b expected 0 1", rf_we, in_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    drive(2'b01, 32'h0000_6000, 3'b010, 5'd20, 1'b1, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || rf_we !== 1'b0 || rf_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_load got ready=%b we=%b rd=%0d expected 1 0 0", in_ready, rf_we, rf_rd);
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    dmem_rvalid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_rvalid_ignored got we=%b ready=%b expected 0 1", rf_we, in_ready);
    end
    in_pc_plus_4 = 32'h0000_9004;
    drive(2'b10, 32'h0, 3'b000, 5'd0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL jal_rd0 got we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      v = $urandom;
      sb.push_back('{K_WR, 5'(i + 1), v});
      drive(2'b00, v, 3'b000, 5'(i + 1), 1'b1, 1'b0, 32'h0);
      checks++;
      if (rf_we !== 1'b1 || rf_wdata !== v || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d] got we=%b wdata=%h ready=%b expected 1 %h 1",
                 i, rf_we, rf_wdata, in_ready, v);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_mem_to_reg = 2'b00;
    in_alu_result = '0;
    in_pc_plus_4  = '0;
    in_alt_data   = '0;
    in_funct3     = 3'b000;
    in_rd         = 5'd0;
    in_reg_write  = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
    #1;
    test_reset();
    test_alu();
    test_load_same_cycle();
    test_load_wait();
    test_misalign();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
